// File: rtl/decode_writeback_if.sv
// Decode/write-back bus: fetch/execute/memory inputs and decoded outputs.
interface decode_writeback_if #(
    parameter int DATA_W = 64
);
    logic [3:0]        icode;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic              cnd;
    logic              wb_en;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;

    modport master (
        output icode, rA, rB, cnd, wb_en, valE, valM,
        input  srcA, srcB, dstE, dstM, valA, valB
    );

    modport slave (
        input  icode, rA, rB, cnd, wb_en, valE, valM,
        output srcA, srcB, dstE, dstM, valA, valB
    );
endinterface

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode + write-back: specifier decode, 15-entry
// register file with combinational reads and edge-committed writes.
module decode_writeback #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input logic                 clk,
    input logic                 reset,
    decode_writeback_if.slave   bus
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [DATA_W-1:0] regs [15];

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        unique case (bus.icode)
            4'h2: begin
                src_a = bus.rA;
                dst_e = bus.cnd ? bus.rB : RNONE;
            end
            4'h3: dst_e = bus.rB;
            4'h4: begin
                src_a = bus.rA;
                src_b = bus.rB;
            end
            4'h5: begin
                src_b = bus.rB;
                dst_m = bus.rA;
            end
            4'h6: begin
                src_a = bus.rA;
                src_b = bus.rB;
                dst_e = bus.rB;
            end
            4'h8: begin
                src_b = RSP;
                dst_e = RSP;
            end
            4'h9: begin
                src_a = RSP;
                src_b = RSP;
                dst_e = RSP;
            end
            4'hA: begin
                src_a = bus.rA;
                src_b = RSP;
                dst_e = RSP;
            end
            4'hB: begin
                src_a = RSP;
                src_b = RSP;
                dst_e = RSP;
                dst_m = bus.rA;
            end
            default: ;
        endcase
    end

    assign bus.srcA = src_a;
    assign bus.srcB = src_b;
    assign bus.dstE = dst_e;
    assign bus.dstM = dst_m;

    // Index F is not stored; it always reads as zero.
    assign bus.valA = (src_a == RNONE) ? '0 : regs[src_a];
    assign bus.valB = (src_b == RNONE) ? '0 : regs[src_b];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= (i == 4) ? RSP_INIT : '0;
            end
        end else if (bus.wb_en) begin
            // M port wins when both target the same register (popq %rsp).
            if (dst_e != RNONE && dst_e != dst_m) begin
                regs[dst_e] <= bus.valE;
            end
            if (dst_m != RNONE) begin
                regs[dst_m] <= bus.valM;
            end
        end
    end
endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: decode table, write-back
// priority, enable gating, SEQ read timing and asynchronous reset.
module tb_decode_writeback;
    localparam int          DATA_W = 64;
    localparam logic [63:0] RSPI   = 64'h100;
    localparam logic [3:0]  F      = 4'hF;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    decode_writeback_if #(.DATA_W(DATA_W)) bus ();

    decode_writeback #(
        .DATA_W   (DATA_W),
        .RSP_INIT (RSPI)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic,
                         input logic [3:0] ra,
                         input logic [3:0] rb,
                         input logic c,
                         input logic en);
        bus.icode = ic;
        bus.rA    = ra;
        bus.rB    = rb;
        bus.cnd   = c;
        bus.wb_en = en;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.wb_en = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        bus.valE = '0;
        bus.valM = '0;
        drive(4'h0, F, F, 1'b0, 1'b0);

        // Asynchronous reset before any clock edge
        #1;
        reset = 1'b1;
        #1;
        drive(4'hB, 4'h4, F, 1'b0, 1'b0);
        check("rst_popq_srcA", {60'd0, bus.srcA}, 64'h4);
        check("rst_popq_valA", bus.valA, RSPI);
        check("rst_popq_valB", bus.valB, RSPI);
        for (int i = 0; i < 15; i++) begin
            if (i != 4) begin
                drive(4'h2, i[3:0], F, 1'b0, 1'b0);
                check($sformatf("rst_r%0d", i), bus.valA, 64'h0);
            end
        end
        drive(4'h0, 4'h1, 4'h2, 1'b1, 1'b0);
        check("halt_srcA", {60'd0, bus.srcA}, {60'd0, F});
        check("halt_dstE", {60'd0, bus.dstE}, {60'd0, F});
        check("halt_valA", bus.valA, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // irmovq -> R2
        bus.valE = 64'h1234;
        drive(4'h3, F, 4'h2, 1'b0, 1'b1);
        check("irm_dstE", {60'd0, bus.dstE}, 64'h2);
        check("irm_srcA", {60'd0, bus.srcA}, {60'd0, F});
        tick();
        drive(4'h2, 4'h2, 4'h7, 1'b0, 1'b0);
        check("rrm_valA", bus.valA, 64'h1234);

        // cmovXX gated by cnd
        bus.valE = 64'h7;
        drive(4'h2, 4'h1, 4'h3, 1'b0, 1'b1);
        check("cmov0_dstE", {60'd0, bus.dstE}, {60'd0, F});
        tick();
        drive(4'h6, 4'h1, 4'h3, 1'b0, 1'b0);
        check("cmov0_r3", bus.valB, 64'h0);
        drive(4'h2, 4'h1, 4'h3, 1'b1, 1'b1);
        check("cmov1_dstE", {60'd0, bus.dstE}, 64'h3);
        tick();
        drive(4'h6, 4'h1, 4'h3, 1'b0, 1'b0);
        check("cmov1_r3", bus.valB, 64'h7);

        // popq %rsp: M priority
        bus.valE = 64'h108;
        bus.valM = 64'h55;
        drive(4'hB, 4'h4, F, 1'b0, 1'b1);
        check("pop_dstE", {60'd0, bus.dstE}, 64'h4);
        check("pop_dstM", {60'd0, bus.dstM}, 64'h4);
        tick();
        drive(4'hB, 4'h4, F, 1'b0, 1'b0);
        check("pop_r4", bus.valA, 64'h55);

        // mrmovq with enable low then high
        bus.valM = 64'h99;
        drive(4'h5, 4'h5, 4'h1, 1'b0, 1'b0);
        check("mrm_dstM", {60'd0, bus.dstM}, 64'h5);
        check("mrm_srcB", {60'd0, bus.srcB}, 64'h1);
        tick();
        drive(4'h2, 4'h5, F, 1'b0, 1'b0);
        check("mrm_en0_r5", bus.valA, 64'h0);
        drive(4'h5, 4'h5, 4'h1, 1'b0, 1'b1);
        tick();
        drive(4'h2, 4'h5, F, 1'b0, 1'b0);
        check("mrm_en1_r5", bus.valA, 64'h99);

        // OPq: reads show pre-edge values
        bus.valE = 64'hAAAA;
        drive(4'h6, 4'h1, 4'h2, 1'b0, 1'b1);
        check("op_pre_valA", bus.valA, 64'h0);
        check("op_pre_valB", bus.valB, 64'h1234);
        tick();
        drive(4'h6, 4'h1, 4'h2, 1'b0, 1'b0);
        check("op_post_valB", bus.valB, 64'hAAAA);

        // Invalid icodes decode to all-F
        drive(4'h7, 4'h1, 4'h2, 1'b1, 1'b0);
        check("jxx_srcB", {60'd0, bus.srcB}, {60'd0, F});
        drive(4'hC, 4'h1, 4'h2, 1'b1, 1'b0);
        check("ic_c_dstE", {60'd0, bus.dstE}, {60'd0, F});
        check("ic_c_dstM", {60'd0, bus.dstM}, {60'd0, F});

        // Mid-cycle reset clears instantly; reset wins on an edge
        drive(4'h6, 4'h2, 4'h4, 1'b0, 1'b0);
        check("pre_rst_valB", bus.valB, 64'h55);
        reset = 1'b1;
        #1;
        check("mid_rst_valA", bus.valA, 64'h0);
        check("mid_rst_valB", bus.valB, RSPI);
        bus.valE = 64'hDEAD;
        drive(4'h3, F, 4'h2, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.wb_en = 1'b0;
        drive(4'h2, 4'h2, F, 1'b0, 1'b0);
        check("rst_edge_r2", bus.valA, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
